seq_shifter: RTL and testbench
==============================

Name: seq_shifter

Overview:
- Multi-cycle iterative shift unit. Shifts one bit position per clock with a start/busy/done handshake.
- Sequential counterpart of the single-cycle combinational barrel shifter. Same operand and control conventions, so the two are interchangeable behind a handshake wrapper.
- Targets area-constrained datapath variants where the ALU shift path is multi-cycle and the control FSM stalls on busy.

Parameters:
- WIDTH, 32, data width of in/out.
- SHW, 5, number of shamt bits used; shift count range 0..2^SHW-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- in  input  WIDTH  operand; latched when start is accepted.
- shamt  input  32  shift amount; only shamt[SHW-1:0] is used, upper bits ignored.
- dir  input  1  1 = shift left, 0 = shift right; latched at start.
- arith_or_logic  input  1  1 = arithmetic, 0 = logical; affects right shifts only; latched at start.
- out  output  WIDTH  result register; holds the last completed result.
- busy  output  1  high while an operation is in progress (state SHIFT).
- done  output  1  one-cycle pulse coincident with out update.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out=0, busy=0, done=0, internal shift register=0, count=0, state=IDLE.
  - Overrides everything, including start in the same cycle and any operation in progress. An aborted operation produces no done and leaves out=0.
- States: IDLE, SHIFT.
- IDLE:
  - busy=0.
  - If start=1 at an edge: latch in into the shift register, latch count=shamt[SHW-1:0], latch dir and arith_or_logic; next state SHIFT.
  - start=0: stay in IDLE, out unchanged.
- SHIFT:
  - busy=1.
  - At each edge with count!=0, shift the register by one position and decrement count:
    - left: bit 0 is filled with 0.
    - right logical: MSB is filled with 0.
    - right arithmetic: MSB is replicated.
    - left arithmetic is identical to left logical.
  - At the edge with count==0: out<=shift register, done<=1 for one cycle, busy<=0, next state IDLE.
- Latency:
  - Start accepted at edge E0; shifts at E1..Ek (k = latched count); out valid and done=1 after edge E(k+1).
  - Total is k+1 cycles; count 0 takes 1 cycle and gives out=in.
  - Maximum latency is 2^SHW cycles (32 for the defaults).
- start while busy=1 is ignored. It is not queued, and in, shamt, dir and arith_or_logic changes are ignored.
- start in the cycle done=1 (state IDLE) is accepted normally, giving back-to-back operations with no gap cycle.
- done is never high for more than one consecutive cycle unless operations complete in successive cycles.
- out changes only on completion or reset; it is stable during busy.
- All arithmetic is on WIDTH bits; no carry-out or overflow flag is produced.

Test Plan:
- Left shift: rst 2 cycles, then start with in=4567, shamt=4, dir=1, arith_or_logic=0 -> busy high 5 cycles; done pulse with out=73072 (0x00011D70) exactly 5 edges after start.
- Right logical: in=4567, shamt=4, dir=0, arith_or_logic=0 -> out=285. Then in=-64 (0xFFFFFFC0), same controls -> out=0x0FFFFFFC.
- Right arithmetic: in=-64, shamt=4, dir=0, arith_or_logic=1 -> out=0xFFFFFFFC (-4). Repeat with dir=1, arith_or_logic=1 -> out=0xFFFFFC00, same as logical left.
- Boundaries:
  - shamt=0, in=0xDEADBEEF -> out=0xDEADBEEF with done 1 edge after start.
  - in=1, shamt=31, dir=1 -> out=0x80000000 after 32 edges.
  - shamt=36 -> behaves as shamt=4.
- Handshake: pulse start again mid-operation with different in/shamt -> ignored and first result unchanged. Assert start in the done cycle -> second operation accepted with no idle gap.
- Reset mid-operation: rst=1 two cycles into a shamt=10 shift -> next cycle out=0, busy=0, done=0, and no done pulse follows. A subsequent start operates normally.

Source files
------------

// File: rtl/seq_shifter.sv
`default_nettype none
// ============================================================================
// Module      : seq_shifter
// Description : Multi-cycle iterative shift unit. Shifts one bit position per
//               clock behind a start/busy/done handshake. It uses the same
//               operand and control conventions as the single-cycle barrel
//               shifter, so the two are interchangeable behind a handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk            in   1      system clock, rising edge
//   rst            in   1      synchronous active-high reset
//   start          in   1      request pulse, sampled only while idle
//   in             in   WIDTH  operand, latched when start is accepted
//   shamt          in   32     shift amount, only shamt[SHW-1:0] is used
//   dir            in   1      1 = left, 0 = right (latched at start)
//   arith_or_logic in   1      1 = arithmetic, 0 = logical (right shifts only)
//   out            out  WIDTH  last completed result
//   busy           out  1      operation in progress
//   done           out  1      one-cycle pulse coincident with out update
// ============================================================================
module seq_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [31:0]      shamt,
  input  logic             dir,
  input  logic             arith_or_logic,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  // Two states: waiting for a request, or iterating over the shift count.
  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  localparam logic [SHW-1:0] c_count_one = {{(SHW-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_shreg;
  logic [SHW-1:0]   r_count;
  logic             r_dir;
  logic             r_arith;
  logic [WIDTH-1:0] r_out;
  logic             r_done;

  logic             w_accept;
  logic             w_step;
  logic             w_finish;
  logic             w_fill;
  logic [WIDTH-1:0] w_shifted;

  // Only the low SHW bits of the shift amount matter; the rest are reduced
  // into a deliberately unused wire so that ignoring them is explicit.
  if (SHW < 32) begin : g_shamt_upper
    logic w_unused_shamt_hi;
    assign w_unused_shamt_hi = ^shamt[31:SHW];
  end else begin : g_shamt_full
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath control
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // start is not looked at here: requests while busy are dropped.
        if (r_count != '0) begin
          w_step = 1'b1;
        end else begin
          w_finish     = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // One-position shift. Left shifts always fill with zero, so the arithmetic
  // flag only changes the fill bit of a right shift.
  // --------------------------------------------------------------------------
  always_comb begin
    w_fill    = r_arith & r_shreg[WIDTH-1];
    w_shifted = r_shreg;
    if (r_dir) begin
      w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
    end else begin
      w_shifted = {w_fill, r_shreg[WIDTH-1:1]};
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg <= '0;
      r_count <= '0;
      r_dir   <= 1'b0;
      r_arith <= 1'b0;
      r_out   <= '0;
      r_done  <= 1'b0;
    end else begin
      // done is a single-cycle pulse unless re-armed by another completion.
      r_done <= 1'b0;
      if (w_accept) begin
        r_shreg <= in;
        r_count <= shamt[SHW-1:0];
        r_dir   <= dir;
        r_arith <= arith_or_logic;
      end
      if (w_step) begin
        r_shreg <= w_shifted;
        r_count <= r_count - c_count_one;
      end
      if (w_finish) begin
        r_out  <= r_shreg;
        r_done <= 1'b1;
      end
    end
  end

  assign out  = r_out;
  assign busy = (r_state == S_SHIFT);
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_shifter
// Description : Directed self-checking bench for seq_shifter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_shifter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] in;
  logic [31:0] shamt;
  logic        dir;
  logic        arith_or_logic;
  logic [31:0] out;
  logic        busy;
  logic        done;

  int n_checks;
  int n_fail;

  seq_shifter #(
    .WIDTH(32),
    .SHW  (5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .in            (in),
    .shamt         (shamt),
    .dir           (dir),
    .arith_or_logic(arith_or_logic),
    .out           (out),
    .busy          (busy),
    .done          (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and wait (bounded) for done. Returns the result, the
  // number of edges after the accepting edge until done, the number of
  // sampled busy cycles, and whether out stayed stable while busy.
  task automatic do_op(input logic [31:0] a, input logic [31:0] sh,
                       input logic d, input logic ar,
                       output logic [31:0] res, output int lat,
                       output int busy_cyc, output logic stable);
    logic [31:0] o0;
    o0       = out;
    stable   = 1'b1;
    busy_cyc = 0;
    lat      = -1;
    res      = 'x;
    in = a; shamt = sh; dir = d; arith_or_logic = ar; start = 1'b1;
    tick();
    start = 1'b0;
    if (busy) busy_cyc++;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin
        res = out;
        lat = k;
        break;
      end
      if (busy) busy_cyc++;
      if (out !== o0) stable = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in = '0; shamt = '0; dir = 1'b0; arith_or_logic = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    n_checks++; if (out !== 32'h0) begin n_fail++; $display("FAIL reset_out: got %h want %h", out, 32'h0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
  endtask

  task automatic test_left();
    logic [31:0] r; int lat; int bc; logic st;
    do_op(32'd4567, 32'd4, 1'b1, 1'b0, r, lat, bc, st);
    n_checks++; if (r !== 32'h00011D70) begin n_fail++; $display("FAIL left_out: got %h want %h", r, 32'h00011D70); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL left_latency: got %0d want 5", lat); end
    n_checks++; if (bc !== 5) begin n_fail++; $display("FAIL left_busy_cycles: got %0d want 5", bc); end
    n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL left_out_stable: got %b want 1", st); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL left_done_one_cycle: got %b want 0", done); end
  endtask

  task automatic test_right_logical();
    logic [31:0] r; int lat; int bc; logic st;
    do_op(32'd4567, 32'd4, 1'b0, 1'b0, r, lat, bc, st);
    n_checks++; if (r !== 32'd285) begin n_fail++; $display("FAIL rlog_pos_out: got %h want %h", r, 32'd285); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL rlog_pos_latency: got %0d want 5", lat); end
    tick();
    do_op(32'hFFFFFFC0, 32'd4, 1'b0, 1'b0, r, lat, bc, st);
    n_checks++; if (r !== 32'h0FFFFFFC) begin n_fail++; $display("FAIL rlog_neg_out: got %h want %h", r, 32'h0FFFFFFC); end
    n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL rlog_neg_out_stable: got %b want 1", st); end
    tick();
  endtask

  task automatic test_right_arith();
    logic [31:0] r; int lat; int bc; logic st;
    do_op(32'hFFFFFFC0, 32'd4, 1'b0, 1'b1, r, lat, bc, st);
    n_checks++; if (r !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL rarith_out: got %h want %h", r, 32'hFFFFFFFC); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL rarith_latency: got %0d want 5", lat); end
    tick();
    do_op(32'hFFFFFFC0, 32'd4, 1'b1, 1'b1, r, lat, bc, st);
    n_checks++; if (r !== 32'hFFFFFC00) begin n_fail++; $display("FAIL larith_out: got %h want %h", r, 32'hFFFFFC00); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL larith_latency: got %0d want 5", lat); end
    tick();
  endtask

  task automatic test_boundaries();
    logic [31:0] r; int lat; int bc; logic st;
    do_op(32'hDEADBEEF, 32'd0, 1'b1, 1'b0, r, lat, bc, st);
    n_checks++; if (r !== 32'hDEADBEEF) begin n_fail++; $display("FAIL zero_shift_out: got %h want %h", r, 32'hDEADBEEF); end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL zero_shift_latency: got %0d want 1", lat); end
    tick();
    do_op(32'h00000001, 32'd31, 1'b1, 1'b0, r, lat, bc, st);
    n_checks++; if (r !== 32'h80000000) begin n_fail++; $display("FAIL max_shift_out: got %h want %h", r, 32'h80000000); end
    n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL max_shift_latency: got %0d want 32", lat); end
    tick();
    do_op(32'd4567, 32'd36, 1'b1, 1'b0, r, lat, bc, st);
    n_checks++; if (r !== 32'h00011D70) begin n_fail++; $display("FAIL shamt_wrap_out: got %h want %h", r, 32'h00011D70); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL shamt_wrap_latency: got %0d want 5", lat); end
    tick();
  endtask

  task automatic test_ignore_start();
    int lat;
    logic [31:0] r;
    lat = -1;
    r   = 'x;
    in = 32'h0000F000; shamt = 32'd8; dir = 1'b0; arith_or_logic = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      // Disturbing request while busy, with completely different operands.
      if (k == 3) begin
        in = 32'hFFFFFFFF; shamt = 32'd1; dir = 1'b1; arith_or_logic = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done) begin
        r   = out;
        lat = k;
        break;
      end
    end
    start = 1'b0;
    n_checks++; if (r !== 32'h000000F0) begin n_fail++; $display("FAIL ignore_start_out: got %h want %h", r, 32'h000000F0); end
    n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL ignore_start_latency: got %0d want 9", lat); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_start_not_queued: busy got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; int lat; int bc; logic st;
    do_op(32'h12345678, 32'd4, 1'b1, 1'b0, r, lat, bc, st);
    n_checks++; if (r !== 32'h23456780) begin n_fail++; $display("FAIL b2b_first_out: got %h want %h", r, 32'h23456780); end
    // Start is asserted while done is still high: accepted with no gap.
    do_op(32'h80000000, 32'd3, 1'b0, 1'b1, r, lat, bc, st);
    n_checks++; if (r !== 32'hF0000000) begin n_fail++; $display("FAIL b2b_second_out: got %h want %h", r, 32'hF0000000); end
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want 4", lat); end
    n_checks++; if (bc !== 4) begin n_fail++; $display("FAIL b2b_second_busy_cycles: got %0d want 4", bc); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; int lat; int bc; logic st;
    logic saw_done;
    in = 32'h0000FFFF; shamt = 32'd10; dir = 1'b1; arith_or_logic = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (out !== 32'h0) begin n_fail++; $display("FAIL abort_out: got %h want %h", out, 32'h0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", done); end
    saw_done = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b want 0", saw_done); end
    do_op(32'h00000003, 32'd2, 1'b1, 1'b0, r, lat, bc, st);
    n_checks++; if (r !== 32'h0000000C) begin n_fail++; $display("FAIL after_abort_out: got %h want %h", r, 32'h0000000C); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL after_abort_latency: got %0d want 3", lat); end
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_left();
    test_right_logical();
    test_right_arith();
    test_boundaries();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
